mux3: RTL and testbench
=======================

// Module: mux3
//
// PURPOSE
// - Registered 3:1 multiplexer with one-hot select; k-bit data paths.
// - Combinational building block wrapped in an output register so it drops
//   into synchronous datapaths (operand select, bypass/forward paths).
// - Zero select yields zero output; invalid (multi-hot) selects are defined
//   and optionally flagged.
//
// PARAMETERS
// - k   default 4   data width of a0, a1, a2 and b (k >= 1)
//
// PORTS
// - clk      in   1   rising-edge clock; sole clock domain
// - reset    in   1   synchronous, active-high reset
// - a2       in   k   data input 2, chosen by s[2]
// - a1       in   k   data input 1, chosen by s[1]
// - a0       in   k   data input 0, chosen by s[0]
// - s        in   3   one-hot select {s2,s1,s0}
// - b        out  k   registered mux output
// - sel_err  out  1   registered flag: s was multi-hot in the previous cycle
// - Positional order after clk/reset: a2, a1, a0, s, b, sel_err.
// - One clock; reset is synchronous and active-high.
//
// BEHAVIOUR
// - All outputs are registered on rising clk; latency is exactly 1 cycle
//   from a2/a1/a0/s to b and sel_err. No handshake; a new select every cycle.
// - Reset: when reset=1 at a clk edge, b <= 0 and sel_err <= 0. Reset wins
//   over any data/select. Inputs sampled in the reset cycle are discarded.
// - Select decode (next-state value of b):
//     s=3'b001 -> a0 ; s=3'b010 -> a1 ; s=3'b100 -> a2 ; s=3'b000 -> 0.
// - Multi-hot s (3'b011, 101, 110, 111): see CONFIGURATION.
// - Width: b is exactly k bits, no extension/truncation; every bit is
//   selected independently, with no arithmetic.
// - X on an unselected input must not propagate to b (AND-OR structure).
// - sel_err <= 1 only for multi-hot s; otherwise 0. Not sticky.
// - Before the first reset, b and sel_err are undefined; the bench must
//   apply reset first.
//
// CONFIGURATION
// - Macro MUX3_SEL_CHECK_EN:
//   - Defined: multi-hot s forces b <= 0 and sel_err <= 1.
//   - Undefined: b <= bitwise OR of every selected input (pure AND-OR mux).
//     sel_err is tied to constant 0.
//   - Both builds behave the same for s in {000, 001, 010, 100}.
//
// TESTING (k=4; inputs applied, checked one clk later)
// - Reset: reset=1, a0=1, a1=2, a2=4, s=3'b001 -> b=0, sel_err=0. Then
//   release reset and hold inputs -> next cycle b=1.
// - Select sweep: a0=1, a1=2, a2=4. Then s=3'b000 -> b=0; s=3'b001 -> b=1;
//   s=3'b010 -> b=2; s=3'b100 -> b=4. One value per cycle, each with
//   1-cycle latency.
// - Data tracking: s=3'b010, a1 goes 0 -> 15 -> 9 on consecutive cycles ->
//   b follows 0,15,9, delayed by 1 cycle; changes on a0/a2 have no effect.
// - Multi-hot, MUX3_SEL_CHECK_EN defined: a0=1, a1=2, s=3'b011 -> b=0,
//   sel_err=1. Next cycle s=3'b001 -> b=1, sel_err=0.
// - Multi-hot, macro undefined: a0=1, a1=2, a2=4, s=3'b111 -> b=7,
//   sel_err=0.
// - Mid-stream reset: s=3'b100, a2=4, b=4 steady. Pulse reset one cycle ->
//   b=0 that cycle, then b=4 again once reset drops.

Source files
------------

// File: rtl/mux3.sv
// Registered 3:1 one-hot multiplexer with k-bit data paths and 1-cycle latency.
// Define MUX3_SEL_CHECK_EN to zero the output and raise sel_err on multi-hot selects.
module mux3 #(
    parameter int k = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [k-1:0] a2,
    input  logic [k-1:0] a1,
    input  logic [k-1:0] a0,
    input  logic [2:0]   s,
    output logic [k-1:0] b,
    output logic         sel_err
);

`ifdef MUX3_SEL_CHECK_EN
    // True when more than one select line is active.
    function automatic logic is_multi_hot(input logic [2:0] sel);
        logic multi;
        case (sel)
            3'b000, 3'b001, 3'b010, 3'b100: multi = 1'b0;
            default:                        multi = 1'b1;
        endcase
        return multi;
    endfunction
`endif

    logic [k-1:0] and_or_s;
    logic [k-1:0] b_next_s;
    logic         err_next_s;
    logic [k-1:0] b_r;
    logic         sel_err_r;

    // AND-OR gating keeps unselected inputs (even X) away from the output.
    always_comb begin
        and_or_s = ({k{s[0]}} & a0) | ({k{s[1]}} & a1) | ({k{s[2]}} & a2);
    end

    // Next-state decode for the output and the select-error flag.
    always_comb begin
        b_next_s   = and_or_s;
        err_next_s = 1'b0;
`ifdef MUX3_SEL_CHECK_EN
        if (is_multi_hot(s)) begin
            b_next_s   = {k{1'b0}};
            err_next_s = 1'b1;
        end else begin
            b_next_s   = and_or_s;
            err_next_s = 1'b0;
        end
`endif
    end

    // Output registers; reset discards whatever was sampled this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_r       <= {k{1'b0}};
            sel_err_r <= 1'b0;
        end else begin
            b_r       <= b_next_s;
            sel_err_r <= err_next_s;
        end
    end

    assign b       = b_r;
    assign sel_err = sel_err_r;

endmodule

// File: tb/tb_mux3.sv
// Directed self-checking bench for mux3 (k=4); multi-hot expectations follow
// whichever MUX3_SEL_CHECK_EN build is compiled.
module tb_mux3;
    logic       clk;
    logic       reset;
    logic [3:0] a2;
    logic [3:0] a1;
    logic [3:0] a0;
    logic [2:0] s;
    logic [3:0] b;
    logic       sel_err;

    int errors = 0;
    int checks = 0;

    mux3 #(.k(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .a2     (a2),
        .a1     (a1),
        .a0     (a0),
        .s      (s),
        .b      (b),
        .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven 1 time unit after a rising edge; step waits for the
    // next edge and settles so outputs are read away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; a0 = 4'd1; a1 = 4'd2; a2 = 4'd4; s = 3'b001;
        step();
        checks++;
        if (b !== 4'd0) begin errors++; $display("FAIL reset_b: got %0d expected 0", b); end
        checks++;
        if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %0b expected 0", sel_err); end
        reset = 1'b0;
        step();
        checks++;
        if (b !== 4'd1) begin errors++; $display("FAIL reset_release_b: got %0d expected 1", b); end
    endtask

    task automatic test_select_sweep();
        logic [2:0] sel_tab [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        logic [3:0] exp_tab [4] = '{4'd0, 4'd1, 4'd2, 4'd4};
        a0 = 4'd1; a1 = 4'd2; a2 = 4'd4;
        for (int i = 0; i < 4; i++) begin
            s = sel_tab[i];
            step();
            checks++;
            if (b !== exp_tab[i]) begin
                errors++;
                $display("FAIL sweep_b s=%b: got %0d expected %0d", sel_tab[i], b, exp_tab[i]);
            end
            checks++;
            if (sel_err !== 1'b0) begin
                errors++;
                $display("FAIL sweep_sel_err s=%b: got %0b expected 0", sel_tab[i], sel_err);
            end
        end
    endtask

    task automatic test_data_tracking();
        logic [3:0] a1_tab [3] = '{4'd0, 4'd15, 4'd9};
        logic [3:0] a0_tab [3] = '{4'd5, 4'd3, 4'd12};
        logic [3:0] a2_tab [3] = '{4'd10, 4'd6, 4'd7};
        s = 3'b010;
        for (int i = 0; i < 3; i++) begin
            a1 = a1_tab[i]; a0 = a0_tab[i]; a2 = a2_tab[i];
            step();
            checks++;
            if (b !== a1_tab[i]) begin
                errors++;
                $display("FAIL track_b step %0d: got %0d expected %0d", i, b, a1_tab[i]);
            end
        end
        // Every bit passes independently through each leg.
        a0 = 4'hA; a1 = 4'h5; a2 = 4'h3; s = 3'b001;
        step();
        checks++;
        if (b !== 4'hA) begin errors++; $display("FAIL bits_a0: got %h expected a", b); end
        s = 3'b100;
        step();
        checks++;
        if (b !== 4'h3) begin errors++; $display("FAIL bits_a2: got %h expected 3", b); end
    endtask

    task automatic test_multi_hot();
`ifdef MUX3_SEL_CHECK_EN
        a0 = 4'd1; a1 = 4'd2; a2 = 4'd4; s = 3'b011;
        step();
        checks++;
        if (b !== 4'd0) begin errors++; $display("FAIL multihot_b: got %0d expected 0", b); end
        checks++;
        if (sel_err !== 1'b1) begin errors++; $display("FAIL multihot_sel_err: got %0b expected 1", sel_err); end
        s = 3'b111;
        step();
        checks++;
        if (b !== 4'd0 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL multihot_111: got b=%0d err=%0b expected b=0 err=1", b, sel_err);
        end
        s = 3'b001;
        step();
        checks++;
        if (b !== 4'd1) begin errors++; $display("FAIL multihot_recover_b: got %0d expected 1", b); end
        checks++;
        if (sel_err !== 1'b0) begin errors++; $display("FAIL multihot_recover_err: got %0b expected 0", sel_err); end
`else
        logic [2:0] sel_tab [4] = '{3'b111, 3'b011, 3'b101, 3'b110};
        logic [3:0] exp_tab [4] = '{4'd7, 4'd3, 4'd5, 4'd6};
        a0 = 4'd1; a1 = 4'd2; a2 = 4'd4;
        for (int i = 0; i < 4; i++) begin
            s = sel_tab[i];
            step();
            checks++;
            if (b !== exp_tab[i]) begin
                errors++;
                $display("FAIL multihot_or_b s=%b: got %0d expected %0d", sel_tab[i], b, exp_tab[i]);
            end
            checks++;
            if (sel_err !== 1'b0) begin
                errors++;
                $display("FAIL multihot_or_err s=%b: got %0b expected 0", sel_tab[i], sel_err);
            end
        end
        a0 = 4'd5; a2 = 4'd10; s = 3'b101;
        step();
        checks++;
        if (b !== 4'd15) begin errors++; $display("FAIL multihot_or_bits: got %0d expected 15", b); end
`endif
    endtask

    task automatic test_midstream_reset();
        a0 = 4'd1; a1 = 4'd2; a2 = 4'd4; s = 3'b100;
        step();
        checks++;
        if (b !== 4'd4) begin errors++; $display("FAIL midreset_pre: got %0d expected 4", b); end
        reset = 1'b1;
        step();
        checks++;
        if (b !== 4'd0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_active: got b=%0d err=%0b expected b=0 err=0", b, sel_err);
        end
        reset = 1'b0;
        step();
        checks++;
        if (b !== 4'd4) begin errors++; $display("FAIL midreset_post: got %0d expected 4", b); end
    endtask

    initial begin
        reset = 1'b1; a0 = 4'd0; a1 = 4'd0; a2 = 4'd0; s = 3'b000;
        #1;
        test_reset();
        test_select_sweep();
        test_data_tracking();
        test_multi_hot();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
